// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register file write port; `define WB_ARB_BYPASS_EN to add decode bypass taps
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hold,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [5*NUM_REQ-1:0]    req_rd_addr,
   input  logic [32*NUM_REQ-1:0]   req_rd_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    rf_write_enable,
   output logic [4:0]              rf_rd_addr,
   output logic [31:0]             rf_rd_data,
`ifdef WB_ARB_BYPASS_EN
   input  logic [4:0]              byp_rs1_addr,
   input  logic [4:0]              byp_rs2_addr,
   output logic                    byp_rs1_hit,
   output logic                    byp_rs2_hit,
   output logic [31:0]             byp_rs1_data,
   output logic [31:0]             byp_rs2_data,
`endif
   output logic [CNT_W-1:0]        conflict_cnt
);
   localparam int IW = $clog2(NUM_REQ);
   logic [IW-1:0] ptr;
   logic [IW-1:0] gidx;
   logic          found;
   logic          grant;
   logic          contend;
   logic [4:0]    g_addr;
   logic [31:0]   g_data;
   // first valid requester searching from ptr upward, wrapping
   always_comb begin
      found = 1'b0;
      gidx = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
            found = 1'b1;
            gidx = IW'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end
   assign grant = found && !hold && rst;
   assign req_ready = grant ? NUM_REQ'(1) << gidx : '0;
   assign g_addr = req_rd_addr[5*gidx +: 5];
   assign g_data = req_rd_data[32*gidx +: 32];
   assign contend = !hold && ($countones(req_valid) > 1);
   // pointer, registered write stage and saturating contention counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
         rf_write_enable <= 1'b0;
         rf_rd_addr <= '0;
         rf_rd_data <= '0;
         conflict_cnt <= '0;
      end else begin
         rf_write_enable <= grant && (g_addr != 5'd0);
         if (grant) begin
            ptr <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            rf_rd_addr <= g_addr;
            rf_rd_data <= g_data;
         end
         if (contend && !(&conflict_cnt))
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end
`ifdef WB_ARB_BYPASS_EN
   assign byp_rs1_hit = rf_write_enable && (rf_rd_addr == byp_rs1_addr) && (byp_rs1_addr != 5'd0);
   assign byp_rs2_hit = rf_write_enable && (rf_rd_addr == byp_rs2_addr) && (byp_rs2_addr != 5'd0);
   assign byp_rs1_data = byp_rs1_hit ? rf_rd_data : '0;
   assign byp_rs2_data = byp_rs2_hit ? rf_rd_data : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors for the writeback arbiter
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        hold;
   logic [2:0]  req_valid;
   logic [14:0] req_rd_addr;
   logic [95:0] req_rd_data;
   logic [2:0]  req_ready;
   logic        rf_write_enable;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;
   logic [15:0] conflict_cnt;
`ifdef WB_ARB_BYPASS_EN
   logic [4:0]  byp_rs1_addr, byp_rs2_addr;
   logic        byp_rs1_hit, byp_rs2_hit;
   logic [31:0] byp_rs1_data, byp_rs2_data;
`endif
   int n_vec = 0;
   int n_miss = 0;

   regfile_wb_arbiter #(.NUM_REQ(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req_valid(req_valid), .req_rd_addr(req_rd_addr), .req_rd_data(req_rd_data),
      .req_ready(req_ready), .rf_write_enable(rf_write_enable),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
`ifdef WB_ARB_BYPASS_EN
      .byp_rs1_addr(byp_rs1_addr), .byp_rs2_addr(byp_rs2_addr),
      .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit),
      .byp_rs1_data(byp_rs1_data), .byp_rs2_data(byp_rs2_data),
`endif
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      req_rd_addr[5*i +: 5] = a;
      req_rd_data[32*i +: 32] = d;
   endtask

   initial begin
      rst = 1'b0;
      hold = 1'b0;
      req_valid = 3'b111;
      req_rd_addr = '0;
      req_rd_data = '0;
`ifdef WB_ARB_BYPASS_EN
      byp_rs1_addr = '0;
      byp_rs2_addr = '0;
`endif
      #1;
      check("rst_ready", req_ready, 3'b000);
      check("rst_we", rf_write_enable, 1'b0);
      check("rst_addr", rf_rd_addr, 5'd0);
      check("rst_data", rf_rd_data, 32'd0);
      check("rst_cnt", conflict_cnt, 16'd0);
      @(negedge clk);
      req_valid = 3'b000;
      rst = 1'b1;
      // single requester
      @(negedge clk);
      set_req(1, 5'd5, 32'hDEADBEEF);
      req_valid = 3'b010;
      #1 check("single_ready", req_ready, 3'b010);
      @(negedge clk);
      check("single_we", rf_write_enable, 1'b1);
      check("single_addr", rf_rd_addr, 5'd5);
      check("single_data", rf_rd_data, 32'hDEADBEEF);
      req_valid = 3'b000;
      #1 check("single_idle_ready", req_ready, 3'b000);
      @(negedge clk);
      check("single_we_drop", rf_write_enable, 1'b0);
      check("single_addr_hold", rf_rd_addr, 5'd5);
      // round robin from a fresh reset
      rst = 1'b0;
      #1 rst = 1'b1;
      set_req(0, 5'd10, 32'hA0000000);
      set_req(1, 5'd11, 32'hA0000001);
      set_req(2, 5'd12, 32'hA0000002);
      req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1 check("rr_ready", req_ready, 3'b001 << (i % 3));
         @(negedge clk);
         check("rr_we", rf_write_enable, 1'b1);
         check("rr_addr", rf_rd_addr, 5'd10 + 5'(i % 3));
         check("rr_data", rf_rd_data, 32'hA0000000 + 32'(i % 3));
      end
      check("rr_cnt", conflict_cnt, 16'd6);
      // x0 write consumes a slot but never writes
      set_req(0, 5'd0, 32'h1234);
      req_valid = 3'b001;
      #1 check("x0_ready", req_ready, 3'b001);
      @(negedge clk);
      check("x0_we", rf_write_enable, 1'b0);
      req_valid = 3'b011;
      #1 check("x0_next_ready", req_ready, 3'b010);
      @(negedge clk);
      check("x0_next_we", rf_write_enable, 1'b1);
      check("x0_next_addr", rf_rd_addr, 5'd11);
      check("x0_cnt", conflict_cnt, 16'd7);
      // hold freezes grants and the counter
      req_valid = 3'b111;
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("hold_ready", req_ready, 3'b000);
         @(negedge clk);
         check("hold_we", rf_write_enable, 1'b0);
      end
      check("hold_cnt", conflict_cnt, 16'd7);
      hold = 1'b0;
      #1 check("release_ready", req_ready, 3'b100);
      @(negedge clk);
      check("release_we", rf_write_enable, 1'b1);
      check("release_addr", rf_rd_addr, 5'd12);
      check("release_data", rf_rd_data, 32'hA0000002);
      check("release_cnt", conflict_cnt, 16'd8);
      // async reset drops an in-flight write
      req_valid = 3'b100;
      set_req(2, 5'd7, 32'h77);
      #1 check("flight_ready", req_ready, 3'b100);
      @(posedge clk);
      #2 check("flight_we", rf_write_enable, 1'b1);
      check("flight_addr", rf_rd_addr, 5'd7);
      rst = 1'b0;
      #1 check("arst_we", rf_write_enable, 1'b0);
      check("arst_addr", rf_rd_addr, 5'd0);
      check("arst_cnt", conflict_cnt, 16'd0);
      check("arst_ready", req_ready, 3'b000);
      req_valid = 3'b000;
      #1 rst = 1'b1;
      @(negedge clk);
      check("arst_no_write", rf_write_enable, 1'b0);
      // pointer returns to 0 on async reset
      req_valid = 3'b001;
      #1 check("ptr_pre_ready", req_ready, 3'b001);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 rst = 1'b1;
      req_valid = 3'b111;
      #1 check("ptr_reset_ready", req_ready, 3'b001);
      @(negedge clk);
      req_valid = 3'b000;
`ifdef WB_ARB_BYPASS_EN
      set_req(0, 5'd9, 32'hCAFE0001);
      req_valid = 3'b001;
      byp_rs1_addr = 5'd9;
      byp_rs2_addr = 5'd0;
      @(negedge clk);
      req_valid = 3'b000;
      check("byp_we", rf_write_enable, 1'b1);
      check("byp_rs1_hit", byp_rs1_hit, 1'b1);
      check("byp_rs1_data", byp_rs1_data, 32'hCAFE0001);
      check("byp_rs2_hit", byp_rs2_hit, 1'b0);
      check("byp_rs2_data", byp_rs2_data, 32'd0);
      @(negedge clk);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters (e.g. ALU, load unit, CSR unit).
- Round-robin arbitration with a valid/ready handshake per requester.
- The winning write is registered, then driven onto the register file write port one cycle after the handshake.
- Sits between the execute/memory writeback sources and the register file; also keeps a saturating contention counter for performance debug.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- hold  input  1  pipeline freeze; when 1, no grant is issued.
- req_valid  input  NUM_REQ  bit i: requester i has a pending write.
- req_rd_addr  input  5*NUM_REQ  destination register of requester i, at bits [5i+4:5i].
- req_rd_data  input  32*NUM_REQ  write data of requester i, at bits [32i+31:32i].
- req_ready  output  NUM_REQ  one-hot grant; combinational from req_valid, hold and the pointer.
- rf_write_enable  output  1  register file write enable.
- rf_rd_addr  output  5  register file destination address.
- rf_rd_data  output  32  register file write data.
- conflict_cnt  output  CNT_W  cycles in which 2 or more requesters were valid and not held.

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_write_enable=0, rf_rd_addr=0, rf_rd_data=0, conflict_cnt=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - req_ready is 0 while in reset.
  - If reset asserts mid-operation, any in-flight registered write is dropped.
- Handshake:
  - A transfer occurs on a rising edge when req_valid[i]=1 and req_ready[i]=1.
  - A requester must hold valid, rd_addr and rd_data stable until it is granted.
  - Deasserting valid before grant is allowed and withdraws the request.
- Arbitration:
  - At most one req_ready bit is high per cycle.
  - If hold=1 or no valid requester: req_ready=0.
  - Otherwise grant the first valid index searching ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On a grant to index g, ptr becomes (g+1) mod NUM_REQ; with no grant, ptr is unchanged.
- Output stage (latency 1):
  - On the edge of a grant to g, the stage captures req_rd_addr[g] and req_rd_data[g].
  - rf_write_enable is set to 1 if that address is nonzero, else 0.
  - On an edge with no grant, rf_write_enable goes to 0; rf_rd_addr and rf_rd_data hold their last values.
  - rf_write_enable is never high for more than one cycle per transfer.
  - The write reaches the register file on the following edge (total 2 edges from request grant to architectural update).
- x0 requests:
  - They arbitrate and consume a slot normally and are acknowledged.
  - They never assert rf_write_enable.
- Contention counter:
  - Increments by 1 on each edge where hold=0 and popcount(req_valid)≥2.
  - Saturates at all-ones; no wrap.
- Same-address back-to-back writes from different requesters are each forwarded in grant order; the later one wins in the register file.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN
- Defined:
  - Adds inputs byp_rs1_addr and byp_rs2_addr (5 bits each).
  - Adds outputs byp_rs1_hit, byp_rs2_hit (1 bit each) and byp_rs1_data, byp_rs2_data (32 bits each).
  - byp_rsN_hit = rf_write_enable && (rf_rd_addr == byp_rsN_addr) && (byp_rsN_addr != 0), purely combinational.
  - byp_rsN_data = rf_rd_data when hit, else 0.
  - Lets decode forward the value about to be written.
- Not defined: these ports do not exist; the core behaviour is identical.

Test Plan:
- Single requester: reset, then req_valid=3'b010 with rd_addr=5, data=0xDEADBEEF held until ready. Required: req_ready=010 in the same cycle; next cycle rf_write_enable=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF; the cycle after, rf_write_enable=0.
- Round robin: all three requesters valid continuously for 6 cycles after reset. Required: grant order 0,1,2,0,1,2; conflict_cnt=6; each rf_write_enable pulse carries the matching requester's data.
- x0 write: requester 0 valid with rd_addr=0, data=0x1234. Required: req_ready[0]=1; rf_write_enable stays 0; ptr advances, so the next simultaneous request from 0 and 1 grants 1.
- Hold: all valid, hold=1 for 3 cycles, then released. Required: req_ready=0 and rf_write_enable=0 during hold; conflict_cnt unchanged; first grant after release goes to the pre-hold pointer index.
- Async reset mid-flight: grant requester 2 (rd_addr=7), then pulse rst low between edges. Required: rf_write_enable drops to 0 immediately; ptr=0; conflict_cnt=0; no write to x7 occurs.
- Bypass (WB_ARB_BYPASS_EN defined): a registered write to x9 of 0xCAFE0001 with byp_rs1_addr=9 and byp_rs2_addr=0. Required: byp_rs1_hit=1 with data 0xCAFE0001; byp_rs2_hit=0 with data 0.
